// File: rtl/spi_byte_master.sv
// Byte-level SPI Mode 0 master with CS setup/hold timing and an optional CS hold between bytes.
// Optional receive loopback (mosi -> rx path) is compiled in with SPI_LOOPBACK_EN.
module spi_byte_master #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned CS_SETUP = 2,
  parameter int unsigned CS_HOLD  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tx_data,
  input  logic       hold_cs,
`ifdef SPI_LOOPBACK_EN
  input  logic       loopback,
`endif
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       spi_active,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso,
  output logic       cs_n
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned BIT_W = 3;
  localparam logic [CNT_W-1:0] DIV_TC   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] SETUP_TC = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] HOLD_TC  = CNT_W'(CS_HOLD - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_LOW, S_HIGH, S_HOLD, S_HELD
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [6:0]       tx_sh_q, tx_sh_d;
  logic [7:0]       rx_sh_q, rx_sh_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             mosi_q, mosi_d;
  logic             sclk_q, sclk_d;
  logic             cs_n_q, cs_n_d;
  logic             spi_active_q, spi_active_d;
  logic             rx_in_c;

`ifdef SPI_LOOPBACK_EN
  assign rx_in_c = loopback ? mosi_q : miso;
`else
  assign rx_in_c = miso;
`endif

  // State register and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      tx_sh_q      <= '0;
      rx_sh_q      <= '0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      mosi_q       <= 1'b0;
      sclk_q       <= 1'b0;
      cs_n_q       <= 1'b1;
      spi_active_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      tx_sh_q      <= tx_sh_d;
      rx_sh_q      <= rx_sh_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      mosi_q       <= mosi_d;
      sclk_q       <= sclk_d;
      cs_n_q       <= cs_n_d;
      spi_active_q <= spi_active_d;
    end
  end

  // Next-state, counters and shift paths
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    mosi_d     = mosi_q;

    case (state_q)
      S_IDLE: begin
        mosi_d = 1'b0;
        if (start) begin
          tx_sh_d = tx_data[6:0];
          mosi_d  = tx_data[7];
          cnt_d   = '0;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt_q == SETUP_TC) begin
          cnt_d   = '0;
          state_d = S_LOW;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_LOW: begin
        if (cnt_q == DIV_TC) begin
          cnt_d   = '0;
          rx_sh_d = {rx_sh_q[6:0], rx_in_c};
          state_d = S_HIGH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_HIGH: begin
        if (cnt_q == DIV_TC) begin
          cnt_d = '0;
          if (bit_q == BIT_W'(7)) begin
            bit_d      = '0;
            rx_data_d  = rx_sh_q;
            rx_valid_d = 1'b1;
            state_d    = hold_cs ? S_HELD : S_HOLD;
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            mosi_d  = tx_sh_q[6];
            tx_sh_d = {tx_sh_q[5:0], 1'b0};
            state_d = S_LOW;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (cnt_q == HOLD_TC) begin
          cnt_d   = '0;
          mosi_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_HELD: begin
        // A new byte takes priority over releasing the frame
        if (start) begin
          tx_sh_d = tx_data[6:0];
          mosi_d  = tx_data[7];
          cnt_d   = '0;
          state_d = S_LOW;
        end else if (!hold_cs) begin
          cnt_d   = '0;
          state_d = S_HOLD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pin levels follow the state being entered, so they switch on the same edge
  always_comb begin
    cs_n_d       = (state_d == S_IDLE);
    sclk_d       = (state_d == S_HIGH);
    spi_active_d = (state_d != S_IDLE) && (state_d != S_HELD);
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign spi_active = spi_active_q;
  assign sclk       = sclk_q;
  assign mosi       = mosi_q;
  assign cs_n       = cs_n_q;

endmodule

// File: tb/tb_spi_byte_master.sv
// Directed bench for spi_byte_master: default-timing instance with a Mode 0 slave model,
// plus a CLK_DIV=1 instance whose miso is wired back to its mosi.
module tb_spi_byte_master;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] tx_data;
  logic       hold_cs;
  logic       loopback;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       spi_active;
  logic       sclk;
  logic       mosi;
  logic       miso;
  logic       cs_n;

  logic       start_f;
  logic [7:0] tx_f;
  logic [7:0] rx_f;
  logic       rxv_f;
  logic       act_f;
  logic       sclk_f;
  logic       mosi_f;
  logic       cs_f;

  logic [7:0] slave_byte;
  logic [2:0] slv_bit;
  logic       sclk_p;
  logic       cs_n_p;
  logic [7:0] mosi_cap;
  int         rises;
  int         pulses;
  int         n_vec;
  int         n_bad;

  spi_byte_master dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .tx_data   (tx_data),
    .hold_cs   (hold_cs),
`ifdef SPI_LOOPBACK_EN
    .loopback  (loopback),
`endif
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .spi_active(spi_active),
    .sclk      (sclk),
    .mosi      (mosi),
    .miso      (miso),
    .cs_n      (cs_n)
  );

  spi_byte_master #(.CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1)) dut_f (
    .clk       (clk),
    .rst       (rst),
    .start     (start_f),
    .tx_data   (tx_f),
    .hold_cs   (1'b0),
`ifdef SPI_LOOPBACK_EN
    .loopback  (1'b0),
`endif
    .rx_data   (rx_f),
    .rx_valid  (rxv_f),
    .spi_active(act_f),
    .sclk      (sclk_f),
    .mosi      (mosi_f),
    .miso      (mosi_f),
    .cs_n      (cs_f)
  );

  // Mode 0 slave: MSB out when CS falls, next bit after each falling SCLK
  assign miso = slave_byte[3'd7 - slv_bit];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] tx;
    logic [7:0] slave;
    logic [7:0] exp_rx;
    logic [7:0] exp_mosi;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the edge; also runs the monitors
  task automatic tick();
    @(posedge clk);
    #1;
    if (sclk && !sclk_p) begin
      rises++;
      mosi_cap = {mosi_cap[6:0], mosi};
    end
    if (!cs_n && cs_n_p) slv_bit = 3'd0;
    else if (!sclk && sclk_p) slv_bit = slv_bit + 3'd1;
    if (rx_valid) pulses++;
    sclk_p = sclk;
    cs_n_p = cs_n;
  endtask

  task automatic wait_valid(input string nm, output int cyc);
    cyc = -1;
    for (int c = 1; c < 300; c++) begin
      tick();
      if (rx_valid) begin
        cyc = c;
        break;
      end
    end
    if (cyc < 0) chk({nm, "_timeout"}, 32'd0, 32'd1);
  endtask

  // One byte from IDLE with hold_cs=0; checks the full default timing
  task automatic xfer(input string nm, input logic [7:0] tx, input logic [7:0] sl,
                      input logic [7:0] exp_rx, input logic [7:0] exp_mosi);
    int first_rise, vcyc, hicyc;
    logic [7:0] rxd;
    logic cs68;
    first_rise = -1; vcyc = -1; hicyc = -1; rxd = 8'h00; cs68 = 1'b1;
    slave_byte = sl; rises = 0; pulses = 0; mosi_cap = 8'h00;
    tx_data = tx; hold_cs = 1'b0; start = 1'b1;
    tick();
    start = 1'b0; tx_data = ~tx;
    chk({nm, "_csn_T1"}, 32'(cs_n), 32'd0);
    chk({nm, "_act_T1"}, 32'(spi_active), 32'd1);
    for (int c = 1; c < 200; c++) begin
      if (sclk && first_rise < 0) first_rise = c;
      if (rx_valid && vcyc < 0) begin vcyc = c; rxd = rx_data; end
      if (c == 68) cs68 = cs_n;
      if (cs_n) begin hicyc = c; break; end
      tick();
    end
    chk({nm, "_first_rise"}, 32'(first_rise), 32'd7);
    chk({nm, "_rxv_cyc"}, 32'(vcyc), 32'd67);
    chk({nm, "_rx_data"}, 32'(rxd), 32'(exp_rx));
    chk({nm, "_csn_T68"}, 32'(cs68), 32'd0);
    chk({nm, "_csn_hi_cyc"}, 32'(hicyc), 32'd69);
    chk({nm, "_act_idle"}, 32'(spi_active), 32'd0);
    chk({nm, "_mosi_idle"}, 32'(mosi), 32'd0);
    chk({nm, "_rises"}, 32'(rises), 32'd8);
    chk({nm, "_mosi_bits"}, 32'(mosi_cap), 32'(exp_mosi));
    chk({nm, "_pulses"}, 32'(pulses), 32'd1);
  endtask

  initial begin
    vec_t vecs[5];
    int vc, hc, c;
    int first_t, last_t, toggles;
    logic prev_f;
    logic [7:0] rxd;

    vecs[0] = '{tx: 8'h0B, slave: 8'h3C, exp_rx: 8'h3C, exp_mosi: 8'h0B};
    vecs[1] = '{tx: 8'h55, slave: 8'hAA, exp_rx: 8'hAA, exp_mosi: 8'h55};
    vecs[2] = '{tx: 8'hFF, slave: 8'h00, exp_rx: 8'h00, exp_mosi: 8'hFF};
    vecs[3] = '{tx: 8'h00, slave: 8'hFF, exp_rx: 8'hFF, exp_mosi: 8'h00};
    vecs[4] = '{tx: 8'h81, slave: 8'h7E, exp_rx: 8'h7E, exp_mosi: 8'h81};

    n_vec = 0; n_bad = 0;
    rst = 1'b1; start = 1'b0; tx_data = 8'h00; hold_cs = 1'b0; loopback = 1'b0;
    start_f = 1'b0; tx_f = 8'h00;
    slave_byte = 8'h00; slv_bit = 3'd0; sclk_p = 1'b0; cs_n_p = 1'b1;
    mosi_cap = 8'h00; rises = 0; pulses = 0;
    repeat (3) tick();
    chk("rst_csn", 32'(cs_n), 32'd1);
    chk("rst_sclk", 32'(sclk), 32'd0);
    chk("rst_mosi", 32'(mosi), 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_active", 32'(spi_active), 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_csn", 32'(cs_n), 32'd1);

    for (int i = 0; i < 5; i++) xfer($sformatf("vec%0d", i), vecs[i].tx, vecs[i].slave,
                                      vecs[i].exp_rx, vecs[i].exp_mosi);

    // Three-byte frame with CS held between bytes
    rises = 0; c = 0;
    slave_byte = 8'hE7; tx_data = 8'h0B; hold_cs = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    wait_valid("frm_b0", vc);
    chk("frm_b0_rx", 32'(rx_data), 32'hE7);
    tick();
    chk("frm_held_sclk", 32'(sclk), 32'd0);
    chk("frm_held_act", 32'(spi_active), 32'd0);
    repeat (5) begin tick(); if (cs_n) c++; end
    chk("frm_held_csn", 32'(cs_n), 32'd0);
    slave_byte = 8'h42; tx_data = 8'h14; start = 1'b1;
    tick(); start = 1'b0;
    chk("frm_b1_act", 32'(spi_active), 32'd1);
    wait_valid("frm_b1", vc);
    chk("frm_b1_rx", 32'(rx_data), 32'h42);
    tick();
    chk("frm_held2_act", 32'(spi_active), 32'd0);
    slave_byte = 8'hA5; tx_data = 8'h00; start = 1'b1; hold_cs = 1'b0;
    tick(); start = 1'b0;
    repeat (3) begin tick(); if (cs_n) c++; end
    wait_valid("frm_b2", vc);
    chk("frm_b2_rx", 32'(rx_data), 32'hA5);
    chk("frm_b2_mosi", 32'(mosi_cap), 32'h00);
    hc = -1;
    for (int k = 1; k < 10; k++) begin
      tick();
      if (cs_n) begin hc = k; break; end
    end
    chk("frm_cs_hold", 32'(hc), 32'd2);
    chk("frm_cs_glitch", 32'(c), 32'd0);
    chk("frm_rises", 32'(rises), 32'd24);

    // HELD released by hold_cs=0 without a start
    slave_byte = 8'h3C; tx_data = 8'h9A; hold_cs = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    wait_valid("rel", vc);
    tick();
    hold_cs = 1'b0;
    tick();
    chk("rel_act_hold", 32'(spi_active), 32'd1);
    tick();
    chk("rel_csn_h2", 32'(cs_n), 32'd0);
    tick();
    chk("rel_csn_idle", 32'(cs_n), 32'd1);
    tick();

    // start held high with changing tx_data while busy
    rises = 0; pulses = 0; mosi_cap = 8'h00; slave_byte = 8'h00;
    tx_data = 8'h5A; start = 1'b1;
    tick(); tx_data = 8'hFF;
    hc = -1;
    for (int k = 1; k < 200; k++) begin
      if (cs_n) begin hc = k; break; end
      tick();
    end
    chk("busy_csn_hi", 32'(hc), 32'd69);
    chk("busy_mosi", 32'(mosi_cap), 32'h5A);
    chk("busy_pulses", 32'(pulses), 32'd1);
    tick();
    chk("busy_reaccept", 32'(cs_n), 32'd0);
    start = 1'b0;
    wait_valid("busy_b2", vc);
    chk("busy_b2_mosi", 32'(mosi_cap), 32'hFF);
    repeat (3) tick();

    // Reset during the 4th SCLK high phase
    rises = 0; slave_byte = 8'h00; tx_data = 8'hF0; start = 1'b1;
    tick(); start = 1'b0;
    for (int k = 0; k < 200 && !(rises == 4 && sclk); k++) tick();
    chk("rst_mid_reached", 32'(rises), 32'd4);
    rst = 1'b1; pulses = 0;
    tick();
    rst = 1'b0;
    chk("rst_mid_csn", 32'(cs_n), 32'd1);
    chk("rst_mid_sclk", 32'(sclk), 32'd0);
    chk("rst_mid_act", 32'(spi_active), 32'd0);
    chk("rst_mid_rxv", 32'(rx_valid), 32'd0);
    repeat (80) tick();
    chk("rst_mid_no_pulse", 32'(pulses), 32'd0);
    xfer("rst_clean", 8'h55, 8'h96, 8'h96, 8'h55);

    // Fastest timing on the second instance
    tx_f = 8'h81; start_f = 1'b1;
    tick(); start_f = 1'b0;
    first_t = -1; last_t = -1; toggles = 0; vc = -1; hc = -1; prev_f = 1'b0; rxd = 8'h00;
    for (int k = 1; k < 60; k++) begin
      if (sclk_f != prev_f) begin
        toggles++;
        if (first_t < 0) first_t = k;
        last_t = k;
      end
      prev_f = sclk_f;
      if (rxv_f && vc < 0) begin vc = k; rxd = rx_f; end
      if (cs_f) begin hc = k; break; end
      tick();
    end
    chk("fast_toggles", 32'(toggles), 32'd16);
    chk("fast_first_rise", 32'(first_t), 32'd3);
    chk("fast_last_fall", 32'(last_t), 32'd18);
    chk("fast_rxv_cyc", 32'(vc), 32'd18);
    chk("fast_rx", 32'(rxd), 32'h81);
    chk("fast_csn_hi", 32'(hc), 32'd19);
    chk("fast_act", 32'(act_f), 32'd0);

`ifdef SPI_LOOPBACK_EN
    loopback = 1'b1;
    xfer("loopback", 8'hC3, 8'h00, 8'hC3, 8'hC3);
    loopback = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
